// File: rtl/spi_frame_receiver.sv
// spi_frame_receiver: mode-0 SPI slave that assembles 32-bit command frames in the
// system clock domain, presents them on spi_data and strobes latch_data_sn low.
// Frames whose length is not exactly 32 bits are dropped and counted.
// Optional macro SPI_READBACK_EN: shift the last qualified memory_data word out on
// miso during the next frame (first 16 bits, then zeros). Undefined: miso is 0.

module spi_frame_receiver #(
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned LATCH_PULSE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  input  logic [15:0] memory_data,
  input  logic        data_valid_n,
  output logic [31:0] spi_data,
  output logic        latch_data_sn,
  output logic [7:0]  frame_error_count
);

  typedef enum logic [1:0] {StIdle, StShift, StLatch} state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic sclk_s, cs_s, mosi_s;
  logic sclk_last_q, cs_last_q;
  logic sclk_rise_q, sclk_fall_q, cs_rise_q;

  logic [5:0]  bit_cnt_q, bit_cnt_d, cnt_upd;
  logic [31:0] rx_q, rx_d, rx_upd;
  logic [31:0] spi_data_q, spi_data_d;
  logic [7:0]  err_q, err_d;
  logic [3:0]  latch_cnt_q, latch_cnt_d;
  logic        latch_n_q, latch_n_d;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Synchronisers plus registered edge detection on the last two synchronised samples.
  // cs_n resets to its idle (high) level so leaving reset never looks like a frame start.
  always_ff @(posedge clock) begin
    if (reset) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_last_q <= 1'b0;
      cs_last_q   <= 1'b1;
      sclk_rise_q <= 1'b0;
      sclk_fall_q <= 1'b0;
      cs_rise_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_last_q <= sclk_s;
      cs_last_q   <= cs_s;
      sclk_rise_q <= sclk_s & ~sclk_last_q;
      sclk_fall_q <= ~sclk_s & sclk_last_q;
      cs_rise_q   <= cs_s & ~cs_last_q;
    end
  end

  // Bit shifted/counted first so a coincident cs_n rise checks the updated count.
  always_comb begin
    rx_upd  = rx_q;
    cnt_upd = bit_cnt_q;
    if (sclk_rise_q) begin
      rx_upd = {rx_q[30:0], mosi_s};
      if (bit_cnt_q != 6'd33) begin
        cnt_upd = bit_cnt_q + 6'd1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!cs_s) state_d = StShift;
      StShift: if (cs_rise_q) state_d = (cnt_upd == 6'd32) ? StLatch : StIdle;
      StLatch: if (latch_cnt_q == 4'd0) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs and datapath next-state.
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    spi_data_d  = spi_data_q;
    err_d       = err_q;
    latch_cnt_d = latch_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (!cs_s) begin
          bit_cnt_d = 6'd0;
          rx_d      = 32'd0;
        end
      end
      StShift: begin
        rx_d      = rx_upd;
        bit_cnt_d = cnt_upd;
        if (cs_rise_q) begin
          if (cnt_upd == 6'd32) begin
            spi_data_d  = rx_upd;
            latch_cnt_d = 4'(LATCH_PULSE_CYCLES - 1);
          end else if (err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
          end
        end
      end
      StLatch: begin
        if (latch_cnt_q != 4'd0) begin
          latch_cnt_d = latch_cnt_q - 4'd1;
        end
      end
      default: ;
    endcase
    latch_n_d = (state_d != StLatch);
  end

  // Datapath and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      bit_cnt_q   <= 6'd0;
      rx_q        <= 32'd0;
      spi_data_q  <= 32'd0;
      err_q       <= 8'd0;
      latch_cnt_q <= 4'd0;
      latch_n_q   <= 1'b1;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      spi_data_q  <= spi_data_d;
      err_q       <= err_d;
      latch_cnt_q <= latch_cnt_d;
      latch_n_q   <= latch_n_d;
    end
  end

  assign spi_data          = spi_data_q;
  assign latch_data_sn     = latch_n_q;
  assign frame_error_count = err_q;

`ifdef SPI_READBACK_EN
  logic [15:0] readback_q;
  logic [31:0] tx_q, tx_d;
  logic        miso_q, miso_d;

  // Capture the controller's read word whenever it is qualified.
  always_ff @(posedge clock) begin
    if (reset) begin
      readback_q <= 16'd0;
    end else if (!data_valid_n) begin
      readback_q <= memory_data;
    end
  end

  // Load the readback word at frame start, shift out on sclk falling edges.
  always_comb begin
    tx_d = tx_q;
    if (state_q == StIdle && !cs_s) begin
      tx_d = {readback_q, 16'h0000};
    end else if (state_q == StShift && sclk_fall_q) begin
      tx_d = {tx_q[30:0], 1'b0};
    end
    miso_d = (state_d == StShift && !cs_s) ? tx_d[31] : 1'b0;
  end

  // Transmit shift register and registered miso.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_q   <= 32'd0;
      miso_q <= 1'b0;
    end else begin
      tx_q   <= tx_d;
      miso_q <= miso_d;
    end
  end

  assign miso = miso_q;
`else
  logic unused_readback;
  assign unused_readback = ^{memory_data, data_valid_n};
  assign miso = 1'b0;
`endif

endmodule

// File: doc/spi_frame_receiver.md
# spi_frame_receiver

Upstream stage of the actuator system controller: a clock-domain-crossing SPI slave (mode 0, MSB first) that assembles 32-bit command frames into `spi_data` and strobes `latch_data_sn` low. The system controller latches these into its control, address and data fields. Frames of the wrong length are discarded and counted. An optional readback path shifts the controller's last 16-bit memory read word out on `miso` during the next frame.

## Interface
- `SYNC_STAGES`, default 2: synchroniser depth for `sclk`, `cs_n` and `mosi`; legal range 2–3.
- `LATCH_PULSE_CYCLES`, default 4: length of the low pulse on `latch_data_sn`, in clocks; legal range 1–15.
- `clock` in 1: system clock; must be ≥ 8× the SCLK frequency.
- `reset` in 1: synchronous, active-high reset.
- `sclk` in 1: SPI clock, asynchronous to `clock`, idles low.
- `cs_n` in 1: SPI chip select, active low, asynchronous.
- `mosi` in 1: SPI data in, asynchronous.
- `miso` out 1: SPI data out, registered in the `clock` domain.
- `memory_data` in 16: read data from the system controller.
- `data_valid_n` in 1: active-low qualifier for `memory_data`.
- `spi_data` out 32: last valid frame; bits [31:24] control, [23:16] address, [15:0] data.
- `latch_data_sn` out 1: active-low frame-valid strobe.
- `frame_error_count` out 8: saturating count of discarded frames.

## Operation
- **Synchronisers:** `sclk`, `cs_n` and `mosi` each pass through `SYNC_STAGES` flip-flops. Edges are detected from the last two synchronised samples of each signal.
- **State machine:** states are IDLE, SHIFT and LATCH.
  - IDLE → SHIFT when synchronised `cs_n` is 0. On entry: `bit_count` ← 0, `rx_shift` ← 0, and `tx_shift` is loaded (see Configuration).
  - SHIFT, on each `sclk` rising edge: `rx_shift` ← {`rx_shift`[30:0], `mosi_s`}. `bit_count` is 6 bits and increments, saturating at 33.
  - SHIFT, on a `cs_n` rising edge:
    - If `bit_count` == 32: `spi_data` ← `rx_shift`, then → LATCH.
    - Otherwise (0–31 or ≥33 bits): `frame_error_count` increments, saturating at 255; `spi_data` is unchanged; → IDLE.
  - LATCH: `latch_data_sn` = 0 for exactly `LATCH_PULSE_CYCLES` clocks (4-bit down-counter), then → IDLE. `sclk` and `cs_n` edges are ignored in LATCH.
- **Same-cycle `sclk` rise and `cs_n` rise:** the bit is shifted and counted first, and the length check uses the updated count.
- **`cs_n` still low on return to IDLE:** SHIFT is re-entered immediately. Bits clocked during LATCH are lost, so that frame fails the length check.
- **Required host gap:** `cs_n` must stay high for ≥ `LATCH_PULSE_CYCLES` + `SYNC_STAGES` + 3 clocks between frames.
- **`miso`:** driven 0 whenever synchronised `cs_n` is 1. In SHIFT, `miso` = `tx_shift`[31], and `tx_shift` shifts left (filling with 0) on each `sclk` falling edge.
- **`reset` at any time:** state → IDLE; `spi_data` = 0, `latch_data_sn` = 1, `miso` = 0, `frame_error_count` = 0, `readback_reg` = 0; counters and shift registers are cleared. A `reset` asserted mid-frame aborts the frame without counting an error.

## Timing
- Reset values of outputs: `spi_data` 0, `latch_data_sn` 1, `miso` 0, `frame_error_count` 0.
- Clock edge N is the edge on which `cs_n` high is first registered in synchroniser stage 1. The rising edge is detected at edge N+`SYNC_STAGES`.
- `spi_data` and `latch_data_sn` = 0 become visible after edge N+`SYNC_STAGES`+1.
- `latch_data_sn` returns to 1 after edge N+`SYNC_STAGES`+1+`LATCH_PULSE_CYCLES`.
- `spi_data` changes only on valid frames and is stable for the whole low pulse and beyond.
- `frame_error_count` updates on the same edge on which `spi_data` would have updated.
- `miso` updates `SYNC_STAGES`+1 clocks after the `sclk` falling edge. The 8× clock ratio guarantees `miso` is settled before the next `sclk` rising edge.

## Configuration
- Macro: `SPI_READBACK_EN`.
- **Defined:**
  - `readback_reg` (16-bit) ← `memory_data` on every clock where `data_valid_n` = 0.
  - On IDLE → SHIFT, `tx_shift` ← {`readback_reg`, 16'h0000}.
  - The host therefore reads the most recent memory word in the first 16 bits of the next frame, followed by 16 zero bits.
- **Not defined:** `readback_reg` and `tx_shift` are not built, `miso` is tied to 0, and `memory_data` and `data_valid_n` are unused.

## Test plan
- **Valid frame:** `reset` for 2 clocks, then send 32'hA5_3C_1234 at clock/SCLK = 8. Expect `spi_data` = 32'hA53C1234, `latch_data_sn` low for exactly 4 clocks beginning `SYNC_STAGES`+1 clocks after `cs_n` rises, and `frame_error_count` = 0.
- **Short frame:** send 31 bits of 0x7FFFFFFF. Expect `spi_data` to hold its previous value, no `latch_data_sn` pulse, and `frame_error_count` = 1. A 33-bit frame also gives 2.
- **Counter saturation:** send 260 zero-bit frames (`cs_n` low then high with no `sclk`). Expect `frame_error_count` = 255.
- **Back-to-back frames:** 0x01000001 then 0x02000002 with the minimum legal gap. Expect two `latch_data_sn` pulses. Violating the gap by 3 clocks makes the second frame fail, incrementing `frame_error_count`.
- **Reset mid-frame:** assert `reset` after bit 17, then send 0xFFFFFFFF. Expect all outputs at reset values during reset, then `spi_data` = 0xFFFFFFFF with `frame_error_count` unchanged at 0.
- **Readback (`SPI_READBACK_EN`):** drive `memory_data` = 16'hBEEF with a 1-clock `data_valid_n` low pulse, then run a frame. Expect `miso` to present 1011111011101111 followed by 16 zeros, and `miso` = 0 while `cs_n` is high.
